// File: rtl/ppu_pkg.sv
// ppu_pkg: shared fetch kinds, scheduler states and PPU timing constants.
package ppu_pkg;
    typedef enum logic [1:0] {NT, AT, PT_LO, PT_HI} fetch_kind_e;
    typedef enum logic [1:0] {IDLE, F_ADDR, CPU_ADDR} sched_state_e;
    localparam logic [13:0] NT_BASE      = 14'h2000;
    localparam logic [13:0] AT_BASE      = 14'h23C0;
    localparam logic [8:0]  LAST_VISIBLE = 9'd239;
    localparam logic [8:0]  PRE_RENDER   = 9'd511;
    localparam logic [8:0]  BG_END       = 9'd256;
    localparam logic [8:0]  SPR_END      = 9'd320;
    localparam logic [8:0]  PREFETCH_END = 9'd336;
endpackage

// File: rtl/ppu_fetch_addr_gen.sv
// ppu_fetch_addr_gen: combinational VRAM address for a background or sprite fetch slot.
module ppu_fetch_addr_gen
    import ppu_pkg::*;
#(
    parameter int AW = 14
) (
    input  fetch_kind_e   kind,
    input  logic          spr,
    input  logic [14:0]   vaddr,
    input  logic [7:0]    nt_latch,
    input  logic          bg_pt_sel,
    input  logic [AW-1:0] spr_pat_addr,
    output logic [AW-1:0] addr
);
    logic [13:0] nt_a, at_a, pt_a;
    assign nt_a = NT_BASE | {2'b0, vaddr[11:0]};
    assign at_a = AT_BASE | {2'b0, vaddr[11:10], 10'b0} | {8'b0, vaddr[9:7], 3'b0} | {11'b0, vaddr[4:2]};
    assign pt_a = {1'b0, bg_pt_sel, nt_latch, kind == PT_HI, vaddr[14:12]};
    // sprite window turns NT/AT slots into dummy NT reads
    assign addr = (kind == NT || (spr && kind == AT)) ? AW'(nt_a)
                : kind == AT ? AW'(at_a)
                : spr ? (spr_pat_addr | AW'((kind == PT_HI) ? 4'h8 : 4'h0))
                : AW'(pt_a);
endmodule

// File: rtl/ppu_vram_fetch_sched.sv
// ppu_vram_fetch_sched: arbitrates the single-port VRAM bus between render fetch slots
// and CPU PPUDATA accesses, driven by the scanline/dot timebase.
module ppu_vram_fetch_sched
    import ppu_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [8:0]    scanline,
    input  logic [8:0]    cycle,
    input  logic          is_rendering,
    input  logic          is_pre_render,
    input  logic [14:0]   vaddr,
    input  logic          bg_pt_sel,
    input  logic [AW-1:0] spr_pat_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] vram_addr,
    output logic          vram_rd,
    output logic          vram_wr,
    output logic [DW-1:0] vram_wdata,
    input  logic [DW-1:0] vram_rdata,
    output logic          fetch_valid,
    output logic [1:0]    fetch_kind,
    output logic [DW-1:0] fetch_data,
    output logic          slot_dropped
);
    sched_state_e state, state_d;
    fetch_kind_e kind, kind_q;
    logic render_line, bg_win, spr_win, slot_start, spr_q, issue, accept, drop;
    logic [7:0] nt_latch;
    logic [AW-1:0] gen_addr;

    assign render_line = is_rendering && (scanline <= LAST_VISIBLE || is_pre_render);
    assign bg_win = (cycle >= 9'd1 && cycle <= BG_END) || (cycle > SPR_END && cycle <= PREFETCH_END);
    assign spr_win = cycle > BG_END && cycle <= SPR_END;
    assign slot_start = render_line && cycle[0] && (bg_win || spr_win);
    assign kind = fetch_kind_e'(cycle[2:1]);

    ppu_fetch_addr_gen #(.AW(AW)) u_gen (
        .kind(kind),
        .spr(spr_win),
        .vaddr(vaddr),
        .nt_latch(nt_latch),
        .bg_pt_sel(bg_pt_sel),
        .spr_pat_addr(spr_pat_addr),
        .addr(gen_addr)
    );

    // every access holds the bus for exactly one ce, so non-idle states always return to IDLE
    always_comb begin
        issue = slot_start && state == IDLE;
        drop = slot_start && state != IDLE;
        accept = state == IDLE && !render_line && cpu_req && !cpu_ack && !slot_start;
        state_d = issue ? F_ADDR : accept ? CPU_ADDR : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            kind_q <= NT;
            spr_q <= 1'b0;
            nt_latch <= '0;
            cpu_ack <= 1'b0;
            cpu_rdata <= '0;
            vram_addr <= '0;
            vram_rd <= 1'b0;
            vram_wr <= 1'b0;
            vram_wdata <= '0;
            fetch_valid <= 1'b0;
            fetch_kind <= '0;
            fetch_data <= '0;
            slot_dropped <= 1'b0;
        end else if (ce) begin
            state <= state_d;
            fetch_valid <= state == F_ADDR;
            cpu_ack <= state == CPU_ADDR;
            slot_dropped <= drop;
            vram_rd <= issue || (accept && !cpu_we);
            vram_wr <= accept && cpu_we;
            if (issue) begin
                vram_addr <= gen_addr;
                kind_q <= kind;
                spr_q <= spr_win;
            end
            if (accept) begin
                vram_addr <= cpu_addr;
                vram_wdata <= cpu_wdata;
            end
            if (state == F_ADDR) begin
                fetch_data <= vram_rdata;
                fetch_kind <= kind_q;
                if (kind_q == NT && !spr_q) nt_latch <= vram_rdata[7:0];
            end
            if (state == CPU_ADDR && !vram_wr) cpu_rdata <= vram_rdata;
        end
    end
endmodule

// File: tb/tb_ppu_vram_fetch_sched.sv
// tb_ppu_vram_fetch_sched: directed scenarios plus randomized frames, checked every cycle
// against a transaction-level model of the bus schedule.
module tb_ppu_vram_fetch_sched;
    logic clk = 1'b0, reset = 1'b0, ce = 1'b0;
    logic [8:0] scanline = '0, cycle = '0;
    logic is_rendering = 1'b0, is_pre_render = 1'b0, bg_pt_sel = 1'b0;
    logic [14:0] vaddr = '0;
    logic [13:0] spr_pat_addr = '0, cpu_addr = '0;
    logic cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_wdata = '0;
    logic cpu_ack, vram_rd, vram_wr, fetch_valid, slot_dropped;
    logic [7:0] cpu_rdata, vram_wdata, vram_rdata, fetch_data;
    logic [13:0] vram_addr;
    logic [1:0] fetch_kind;
    logic [7:0] mem [16384];
    logic [7:0] ref_mem [16384];

    int m_op;
    logic [13:0] m_addr;
    logic [7:0] m_wdata, m_ntl;
    logic [1:0] m_kind;
    logic m_bgnt;
    logic e_ack, e_rd, e_wr, e_fv, e_drop;
    logic [7:0] e_rdata, e_wdata, e_fd;
    logic [13:0] e_addr;
    logic [1:0] e_fk;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign vram_rdata = mem[vram_addr];

    ppu_vram_fetch_sched #(.AW(14), .DW(8)) dut (
        .clk(clk), .reset(reset), .ce(ce), .scanline(scanline), .cycle(cycle),
        .is_rendering(is_rendering), .is_pre_render(is_pre_render), .vaddr(vaddr),
        .bg_pt_sel(bg_pt_sel), .spr_pat_addr(spr_pat_addr), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .fetch_valid(fetch_valid),
        .fetch_kind(fetch_kind), .fetch_data(fetch_data), .slot_dropped(slot_dropped)
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (line %0d dot %0d, t=%0t)", nm, got, exp, scanline, cycle, $time);
        end
    endtask

    function automatic logic [13:0] bg_addr(input int k, input int v, input int ntl, input int sel);
        int a;
        if (k == 0) a = 'h2000 + (v & 'hFFF);
        else if (k == 1) a = 'h23C0 + ((v >> 10) & 3) * 1024 + ((v >> 7) & 7) * 8 + ((v >> 2) & 7);
        else a = sel * 4096 + ntl * 16 + ((v >> 12) & 7) + (k == 3 ? 8 : 0);
        return 14'(a);
    endfunction

    task automatic model_reset();
        m_op = 0; m_addr = '0; m_wdata = '0; m_ntl = '0; m_kind = '0; m_bgnt = 1'b0;
        e_ack = 0; e_rd = 0; e_wr = 0; e_fv = 0; e_drop = 0;
        e_rdata = '0; e_wdata = '0; e_fd = '0; e_addr = '0; e_fk = '0;
    endtask

    // one ce edge: retire the transaction that held the bus, then decide who gets it next
    task automatic model_edge();
        int prev, k;
        bit old_ack, rl, slot, spr_w;
        logic [13:0] nt;
        prev = m_op;
        old_ack = e_ack;
        e_fv = prev == 1; e_ack = prev >= 2; e_rd = 0; e_wr = 0; e_drop = 0;
        if (prev == 1) begin
            e_fd = ref_mem[m_addr];
            e_fk = m_kind;
            if (m_bgnt) m_ntl = e_fd;
        end
        if (prev == 2) e_rdata = ref_mem[m_addr];
        if (prev == 3) ref_mem[m_addr] = m_wdata;
        rl = is_rendering && (scanline < 240 || is_pre_render);
        slot = rl && cycle[0] && cycle <= 336;
        k = (int'(cycle) % 8) / 2;
        spr_w = cycle > 256 && cycle <= 320;
        nt = bg_addr(0, int'(vaddr), 0, 0);
        m_op = 0;
        if (slot && prev != 0) e_drop = 1;
        else if (slot) begin
            m_op = 1;
            m_kind = 2'(k);
            m_bgnt = k == 0 && !spr_w;
            m_addr = !spr_w ? bg_addr(k, int'(vaddr), int'(m_ntl), int'(bg_pt_sel))
                   : k < 2 ? nt : (spr_pat_addr | (k == 3 ? 14'h8 : 14'h0));
            e_addr = m_addr;
            e_rd = 1;
        end else if (prev == 0 && !rl && cpu_req && !old_ack) begin
            m_op = cpu_we ? 3 : 2;
            m_addr = cpu_addr; m_wdata = cpu_wdata;
            e_addr = cpu_addr; e_rd = !cpu_we; e_wr = cpu_we; e_wdata = cpu_wdata;
        end
    endtask

    task automatic compare_all();
        chk("cpu_ack", 16'(cpu_ack), 16'(e_ack));
        chk("cpu_rdata", 16'(cpu_rdata), 16'(e_rdata));
        chk("vram_addr", 16'(vram_addr), 16'(e_addr));
        chk("vram_rd", 16'(vram_rd), 16'(e_rd));
        chk("vram_wr", 16'(vram_wr), 16'(e_wr));
        chk("vram_wdata", 16'(vram_wdata), 16'(e_wdata));
        chk("fetch_valid", 16'(fetch_valid), 16'(e_fv));
        chk("fetch_kind", 16'(fetch_kind), 16'(e_fk));
        chk("fetch_data", 16'(fetch_data), 16'(e_fd));
        chk("slot_dropped", 16'(slot_dropped), 16'(e_drop));
        chk("rd_wr_exclusive", 16'(vram_rd && vram_wr), 16'h0);
    endtask

    task automatic tick(input bit c);
        bit w;
        logic [13:0] wa;
        logic [7:0] wd;
        ce = c;
        w = c && vram_wr; wa = vram_addr; wd = vram_wdata;
        @(posedge clk);
        if (reset && c) begin
            if (w) mem[wa] = wd;
            model_edge();
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic step(input bit c);
        tick(c);
        if (c) begin
            if (cycle == 340) begin
                cycle = '0;
                scanline = scanline == 9'd511 ? 9'd0 : 9'(scanline + 1);
                is_pre_render = scanline == 9'd511;
            end else cycle = 9'(cycle + 1);
        end
    endtask

    task automatic set_pos(input int s, input int c);
        scanline = 9'(s); cycle = 9'(c); is_pre_render = s == 511;
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        mem[a] = d; ref_mem[a] = d;
    endtask

    task automatic scen_first(input bit toggle);
        set_pos(0, 0); vaddr = '0; bg_pt_sel = 1; is_rendering = 1;
        poke('h2000, 8'h24);
        for (int c = 0; c <= 8; c++) begin
            if (toggle) step(0);
            step(1);
            if (c == 1) begin chk("s1_nt_addr", 16'(vram_addr), 16'h2000); chk("s1_nt_rd", 16'(vram_rd), 16'h1); end
            else if (c == 2) begin chk("s1_nt_kind", 16'(fetch_kind), 16'h0); chk("s1_nt_data", 16'(fetch_data), 16'h24); chk("s1_nt_fv", 16'(fetch_valid), 16'h1); end
            else if (c == 3) chk("s1_at_addr", 16'(vram_addr), 16'h23C0);
            else if (c == 4) chk("s1_at_kind", 16'(fetch_kind), 16'h1);
            else if (c == 5) chk("s1_ptlo_addr", 16'(vram_addr), 16'h1240);
            else if (c == 6) chk("s1_ptlo_kind", 16'(fetch_kind), 16'h2);
            else if (c == 7) chk("s1_pthi_addr", 16'(vram_addr), 16'h1248);
            else if (c == 8) begin chk("s1_pthi_kind", 16'(fetch_kind), 16'h3); chk("s1_pthi_fv", 16'(fetch_valid), 16'h1); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) poke(i, 8'($urandom));
        model_reset();
        step(0); step(1);
        chk("rst_vram_rd", 16'(vram_rd), 16'h0);
        chk("rst_vram_addr", 16'(vram_addr), 16'h0);
        chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
        reset = 1;

        scen_first(0);

        // sprite window: dummy NT reads must not disturb the NT latch
        poke('h2000, 8'h55);
        spr_pat_addr = 14'h0130;
        set_pos(0, 257);
        for (int c = 257; c <= 264; c++) begin
            step(1);
            if (c == 257 || c == 259) chk("spr_nt_addr", 16'(vram_addr), 16'h2000);
            else if (c == 261) chk("spr_lo_addr", 16'(vram_addr), 16'h0130);
            else if (c == 263) chk("spr_hi_addr", 16'(vram_addr), 16'h0138);
        end
        set_pos(0, 325);
        step(1);
        chk("ntl_kept_addr", 16'(vram_addr), 16'h1240);
        step(1);

        set_pos(245, 100);
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h3F00; cpu_wdata = 8'h0F;
        step(1);
        chk("cw_wr", 16'(vram_wr), 16'h1); chk("cw_rd", 16'(vram_rd), 16'h0);
        chk("cw_addr", 16'(vram_addr), 16'h3F00); chk("cw_ack_early", 16'(cpu_ack), 16'h0);
        step(1);
        chk("cw_wr_drop", 16'(vram_wr), 16'h0); chk("cw_ack", 16'(cpu_ack), 16'h1);
        cpu_req = 0;
        step(1);
        chk("cw_ack_pulse", 16'(cpu_ack), 16'h0);
        chk("cw_mem", 16'(mem['h3F00]), 16'h0F);

        poke('h0155, 8'hA7);
        set_pos(10, 300); is_rendering = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0155;
        for (int c = 300; c <= 340; c++) step(1);
        chk("l10_held_ack", 16'(cpu_ack), 16'h0);
        is_rendering = 0;
        step(1);
        chk("l10_rd", 16'(vram_rd), 16'h1); chk("l10_addr", 16'(vram_addr), 16'h0155);
        step(1);
        chk("l10_ack", 16'(cpu_ack), 16'h1); chk("l10_rdata", 16'(cpu_rdata), 16'hA7);
        cpu_req = 0;
        step(1);

        poke('h0042, 8'hA5);
        set_pos(245, 340); is_rendering = 1; vaddr = 15'h0123;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0042;
        step(1);
        set_pos(0, 0);
        step(1);
        chk("c340_ack", 16'(cpu_ack), 16'h1); chk("c340_rdata", 16'(cpu_rdata), 16'hA5);
        cpu_req = 0;
        step(1);
        chk("c340_no_drop", 16'(slot_dropped), 16'h0);
        chk("c340_slot_rd", 16'(vram_rd), 16'h1);
        chk("c340_slot_addr", 16'(vram_addr), 16'h2123);

        set_pos(0, 0); vaddr = '0;
        step(1); step(1); step(0);
        chk("mid_fetch_rd", 16'(vram_rd), 16'h1);
        #2 reset = 0;
        #1;
        chk("arst_rd", 16'(vram_rd), 16'h0); chk("arst_addr", 16'(vram_addr), 16'h0);
        chk("arst_fv", 16'(fetch_valid), 16'h0); chk("arst_ack", 16'(cpu_ack), 16'h0);
        chk("arst_fdata", 16'(fetch_data), 16'h0);
        model_reset();
        step(0); step(1);
        reset = 1;
        scen_first(1);

        for (int ln = 0; ln < 36; ln++) begin
            case ($urandom % 4)
                0, 1: set_pos(int'($urandom % 240), 0);
                2: set_pos(240 + int'($urandom % 21), 0);
                default: set_pos(511, 0);
            endcase
            is_rendering = ($urandom % 4) != 0;
            bg_pt_sel = 1'($urandom);
            do begin
                if ($urandom % 64 == 0) is_rendering = !is_rendering;
                if ($urandom % 8 == 0) vaddr = 15'($urandom);
                spr_pat_addr = 14'($urandom);
                if (cpu_req && cpu_ack && $urandom % 5 != 0) cpu_req = 0;
                else if (!cpu_req && $urandom % 16 == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 14'($urandom); cpu_wdata = 8'($urandom);
                end
                step(($urandom % 4) != 0);
            end while (cycle != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
